// File: rtl/lc4_div_scheduler.sv
// Shared 16-bit restoring divide/modulo unit for the two-wide LC4 pipe.
// Pipe A has fixed priority over pipe B. Each op takes a fixed 17 cycles from accept to response.
module lc4_div_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_a_valid,
  input  logic [15:0] i_a_dividend,
  input  logic [15:0] i_a_divisor,
  input  logic        i_a_is_mod,
  output logic        o_a_ready,
  input  logic        i_b_valid,
  input  logic [15:0] i_b_dividend,
  input  logic [15:0] i_b_divisor,
  input  logic        i_b_is_mod,
  output logic        o_b_ready,
  input  logic        i_flush,
  output logic        o_resp_valid,
  output logic        o_resp_pipe,
  output logic [15:0] o_resp_result,
  output logic        o_busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef struct packed {
    logic [15:0] dvd;
    logic [15:0] dsr;
    logic        is_mod;
    logic        pipe;
  } req_t;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [15:0] dvd, dsr, rem, quo;
  logic        is_mod, pipe;

  logic        acc, accept;
  req_t        req;
  logic [16:0] rem17;
  logic        ge;
  logic [15:0] rem_nxt, quo_nxt;

  assign acc       = (state == IDLE || state == DONE) && !i_flush;
  assign o_a_ready = acc;
  assign o_b_ready = acc && !i_a_valid;
  assign accept    = acc && (i_a_valid || i_b_valid);

  // B is only selected when A is idle, matching the ready priority.
  always_comb begin
    if (i_a_valid) req = '{dvd: i_a_dividend, dsr: i_a_divisor, is_mod: i_a_is_mod, pipe: 1'b0};
    else           req = '{dvd: i_b_dividend, dsr: i_b_divisor, is_mod: i_b_is_mod, pipe: 1'b1};
  end

  // 17-bit compare keeps the shifted-out MSB of the partial remainder.
  // The 16-bit subtract is exact whenever ge holds, since the difference is below dsr.
  assign rem17   = {rem, dvd[15]};
  assign ge      = rem17 >= {1'b0, dsr};
  assign rem_nxt = ge ? (rem17[15:0] - dsr) : rem17[15:0];
  assign quo_nxt = {quo[14:0], ge};

  assign o_resp_valid = (state == DONE);
  assign o_busy       = (state == BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      dvd           <= '0;
      dsr           <= '0;
      rem           <= '0;
      quo           <= '0;
      is_mod        <= 1'b0;
      pipe          <= 1'b0;
      o_resp_pipe   <= 1'b0;
      o_resp_result <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state  <= BUSY;
            dvd    <= req.dvd;
            dsr    <= req.dsr;
            is_mod <= req.is_mod;
            pipe   <= req.pipe;
            rem    <= '0;
            quo    <= '0;
            cnt    <= '0;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (i_flush) begin
            state <= IDLE;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            dvd <= {dvd[14:0], 1'b0};
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              state         <= DONE;
              o_resp_pipe   <= pipe;
              // Divide by zero runs full length but reports 0.
              o_resp_result <= (dsr == '0) ? '0 : (is_mod ? rem_nxt : quo_nxt);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
